// File: rtl/pattern_eval_sched.sv
// pattern_eval_sched: round-robin scheduler sharing one flop-based pattern
// datapath between NREQ requesters. Each transaction grants one requester,
// latches its input vector, flushes the datapath, holds the inputs for LAT
// edges, captures the outputs and returns them with the requester ID.
// Optional performance counters are enabled by defining PATTERN_EVAL_SCHED_PERF_EN.
module pattern_eval_sched #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int LAT   = 3
) (
    input  logic                   blif_clk_net,
    input  logic                   blif_reset_net,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*IN_W-1:0]   req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    output logic [IN_W-1:0]        dp_in,
    output logic                   dp_reset,
    input  logic [OUT_W-1:0]       dp_out,
`ifdef PATTERN_EVAL_SCHED_PERF_EN
    output logic [15:0]            perf_txn,
    output logic [15:0]            perf_stall,
    input  logic                   perf_clr,
`endif
    output logic                   busy
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   gnt_r;
    logic [3:0]        cnt_r;
    logic [IN_W-1:0]   dp_in_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [OUT_W-1:0]  rsp_data_r;
    logic              busy_r;

    logic              grant_found_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [ID_W:0]     sum_s;
    logic [IN_W-1:0]   sel_data_s;
    logic              accept_s;
    logic              capture_s;
    logic              complete_s;

    // Round-robin search: lowest offset from rr_ptr with a pending request wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_s         = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(i);
            if (sum_s >= (ID_W + 1)'(NREQ)) begin
                sum_s = sum_s - (ID_W + 1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            if (req_valid[sum_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = sum_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Select the granted requester's input slice (one-hot AND-OR mux).
    always_comb begin
        sel_data_s = '0;
        for (int j = 0; j < NREQ; j++) begin
            sel_data_s = sel_data_s |
                         (req_data[j*IN_W +: IN_W] & {IN_W{grant_idx_s == ID_W'(j)}});
        end
    end

    assign accept_s   = (state_r == IDLE) && grant_found_s;
    assign capture_s  = (state_r == EVAL) && (cnt_r == 4'd0);
    assign complete_s = (state_r == RESP) && rsp_valid_r && rsp_ready;

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH: state_s = EVAL;
            EVAL: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = EVAL;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Accept strobe: one-hot to the granted requester, only in IDLE and out of reset.
    always_comb begin
        req_ready = '0;
        if (accept_s && !blif_reset_net) begin
            req_ready = NREQ'(1) << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Sequencer state register and busy flag.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Latch the granted input vector and ID on the accept edge; advance the pointer on completion.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            dp_in_r  <= '0;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            if (accept_s) begin
                dp_in_r <= sel_data_s;
                gnt_r   <= grant_idx_s;
            end
            if (complete_s) begin
                rr_ptr_r <= (gnt_r == LAST_ID) ? '0 : gnt_r + ID_W'(1);
            end
        end
    end

    // Evaluation edge counter: loaded during flush, counts down while evaluating.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            cnt_r <= 4'd0;
        end else if (state_r == FLUSH) begin
            cnt_r <= CNT_INIT;
        end else if ((state_r == EVAL) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response register: capture datapath outputs, hold until the consumer accepts.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= gnt_r;
            rsp_data_r  <= dp_out;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

`ifdef PATTERN_EVAL_SCHED_PERF_EN
    logic [15:0] perf_txn_r;
    logic [15:0] perf_stall_r;

    // Saturating counters of completed responses and backpressured RESP cycles.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            perf_txn_r   <= 16'd0;
            perf_stall_r <= 16'd0;
        end else if (perf_clr) begin
            perf_txn_r   <= 16'd0;
            perf_stall_r <= 16'd0;
        end else begin
            if (complete_s && (perf_txn_r != 16'hFFFF)) begin
                perf_txn_r <= perf_txn_r + 16'd1;
            end
            if ((state_r == RESP) && !rsp_ready && (perf_stall_r != 16'hFFFF)) begin
                perf_stall_r <= perf_stall_r + 16'd1;
            end
        end
    end

    assign perf_txn   = perf_txn_r;
    assign perf_stall = perf_stall_r;
`endif

    // Flush is driven during reset so the datapath starts from a known state.
    assign dp_reset  = blif_reset_net | (state_r == FLUSH);
    assign dp_in     = dp_in_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_pattern_eval_sched.sv
// Directed bench for pattern_eval_sched (NREQ=4, IN_W=11, OUT_W=8, LAT=3).
// The datapath is modelled as a free-running byte counter advanced on each
// falling edge, so a captured rsp_data identifies the edge it was sampled on.
// Perf counter checks are compiled in when PATTERN_EVAL_SCHED_PERF_EN is defined.
module tb_pattern_eval_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic [43:0] req_data = 44'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [10:0] dp_in;
    logic        dp_reset;
    logic [7:0]  dp_out = 8'h00;
    logic        busy;
`ifdef PATTERN_EVAL_SCHED_PERF_EN
    logic [15:0] perf_txn;
    logic [15:0] perf_stall;
    logic        perf_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    pattern_eval_sched #(.NREQ(4), .IN_W(11), .OUT_W(8), .LAT(3)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .dp_in          (dp_in),
        .dp_reset       (dp_reset),
        .dp_out         (dp_out),
`ifdef PATTERN_EVAL_SCHED_PERF_EN
        .perf_txn       (perf_txn),
        .perf_stall     (perf_stall),
        .perf_clr       (perf_clr),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: output changes every falling edge.
    always @(negedge clk) dp_out <= dp_out + 8'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2id(input logic [3:0] oh);
        int r = -1;
        for (int k = 0; k < 4; k++) if (oh[k]) r = k;
        return r;
    endfunction

    int          acc_id [5];
    int          acc_cyc[5];
    int          rsp_ids[5];
    int          n_acc;
    int          n_rsp;
    logic [7:0]  held;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for 3 cycles with all requests pending.
        req_valid = 4'b1111;
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_dp_reset",  32'(dp_reset),  32'h1);
            check("rst_busy",      32'(busy),      32'h0);
        end
        check("rst_dp_in", 32'(dp_in), 32'h0);
        rst = 1'b0;
        #1;
        check("idle_dp_reset", 32'(dp_reset), 32'h0);

        // Round robin with all four requesters held high.
        n_acc = 0;
        n_rsp = 0;
        for (int c = 0; c < 60; c++) begin
            if ((req_ready != 4'b0000) && (n_acc < 5)) begin
                acc_id[n_acc]  = oh2id(req_ready);
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (rsp_valid && (n_rsp < 5)) begin
                rsp_ids[n_rsp] = int'(rsp_id);
                n_rsp++;
            end
            tick();
            if (n_acc == 5) req_valid = 4'b0000;
        end
        check("rr_accepts", 32'(n_acc), 32'd5);
        check("rr_responses", 32'(n_rsp), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_id", 32'(acc_id[k]), 32'(k % 4));
            check("rr_rsp_id", 32'(rsp_ids[k]), 32'(k % 4));
            if (k > 0) check("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd6);
        end

        // Single request from requester 2 (pointer now at 1).
        req_data  = {11'h000, 11'h5A3, 11'h123, 11'h7FF};
        req_valid = 4'b0100;
        #1;
        check("single_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        req_data  = 44'h0;
        #1;
        check("single_ready_drop", 32'(req_ready), 32'h0);
        check("flush_dp_reset", 32'(dp_reset), 32'h1);
        check("flush_dp_in", 32'(dp_in), 32'h5A3);
        check("flush_busy", 32'(busy), 32'h1);
        tick();
        check("eval_dp_reset", 32'(dp_reset), 32'h0);
        check("eval_dp_in", 32'(dp_in), 32'h5A3);
        check("eval_rsp_valid_e1", 32'(rsp_valid), 32'h0);
        tick();
        check("eval_rsp_valid_e2", 32'(rsp_valid), 32'h0);
        tick();
        check("eval_rsp_valid_e3", 32'(rsp_valid), 32'h0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_rsp_data", 32'(rsp_data), 32'(dp_out));
        tick();
        check("single_done_valid", 32'(rsp_valid), 32'h0);
        check("single_done_busy", 32'(busy), 32'h0);
        check("idle_dp_in_held", 32'(dp_in), 32'h5A3);

        // Backpressure: requester 3 served (pointer 3), requester 0 keeps asking.
        rsp_ready = 1'b0;
        req_data  = {11'h7FF, 11'h000, 11'h000, 11'h001};
        req_valid = 4'b1001;
        #1;
        check("bp_req_ready", 32'(req_ready), 32'h8);
        repeat (5) tick();
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp_rsp_id", 32'(rsp_id), 32'd3);
        check("bp_rsp_data", 32'(rsp_data), 32'(dp_out));
        held = rsp_data;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold", {19'h0, rsp_valid, rsp_id, rsp_data, req_ready},
                  {19'h0, 1'b1, 2'd3, held, 4'b0000});
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'h0);
        check("bp_release_busy", 32'(busy), 32'h0);
        check("bp_wrap_grant", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        #1;

        // Reset in the middle of EVAL abandons the transaction.
        req_valid = 4'b0010;
        #1;
        check("mid_req_ready", 32'(req_ready), 32'h2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_dp_reset", 32'(dp_reset), 32'h1);
        tick();
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0011;
        #1;
        check("mid_ptr_zero", 32'(req_ready), 32'h1);
        tick();
        repeat (3) begin
            tick();
            check("mid_no_early_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();
        check("mid_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        check("mid_regrant", 32'(req_ready), 32'h2);
        req_valid = 4'b0000;
        #1;

`ifdef PATTERN_EVAL_SCHED_PERF_EN
        // Five transactions with two stalled RESP cycles each.
        rsp_ready = 1'b0;
        perf_clr  = 1'b1;
        tick();
        perf_clr  = 1'b0;
        check("perf_clr_txn", 32'(perf_txn), 32'd0);
        check("perf_clr_stall", 32'(perf_stall), 32'd0);
        for (int t = 0; t < 5; t++) begin
            req_valid = 4'b0001;
            #1;
            tick();
            req_valid = 4'b0000;
            for (int k = 0; (k < 10) && !rsp_valid; k++) tick();
            check("perf_rsp_seen", 32'(rsp_valid), 32'h1);
            tick();
            tick();
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        check("perf_txn", 32'(perf_txn), 32'd5);
        check("perf_stall", 32'(perf_stall), 32'd10);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr2_txn", 32'(perf_txn), 32'd0);
        check("perf_clr2_stall", 32'(perf_stall), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
